// File: rtl/bin_decode_sequencer_pkg.sv
// Shared types and constants for the CABAC bin decode sequencer slice.
package bin_decode_sequencer_pkg;

    localparam int BIN_WIDTH_DEF      = 3;
    localparam int FIFO_DEPTH_DEF     = 4;
    localparam int BINS_CNT_WIDTH     = 32;
    localparam int BYTES_CNT_WIDTH    = 24;

    // Arithmetic decoder start-of-slice values, shared with the decoder instance.
    localparam logic [8:0]        DEC_INIT_RANGE       = 9'd510;
    localparam logic signed [4:0] DEC_INIT_BITS_NEEDED = -5'sd8;

    typedef enum logic [0:0] {
        WAIT_DATA = 1'b0,
        RUN       = 1'b1
    } seq_state_t;

    function automatic logic [1:0] result_n_bin(input logic bypass, input logic [1:0] n_bin);
        logic [1:0] n_s;
        if (bypass) begin
            n_s = n_bin;
        end else begin
            n_s = 2'd1;
        end
        return n_s;
    endfunction

endpackage

// File: rtl/bin_decode_sequencer_byte_fifo.sv
// Small byte FIFO feeding the arithmetic decoder; head is 0 while empty.
module byte_fifo
    import bin_decode_sequencer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  logic [7:0]              push_data,
    input  logic                    pop,
    output logic [7:0]              head,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    // Byte storage write port.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head byte presented to the decoder.
    always_comb begin
        if (count_r != '0) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = 8'h00;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/bin_decode_sequencer.sv
// Sequences CABAC bin-decode commands so a renormalisation byte is always buffered,
// gates the decoder update and registers its result plus status counters.
module bin_decode_sequencer
    import bin_decode_sequencer_pkg::*;
#(
    parameter int BIN_WIDTH  = BIN_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       bs_valid,
    output logic                       bs_ready,
    input  logic [7:0]                 bs_data,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_bypass,
    input  logic [1:0]                 cmd_n_bin,
    input  logic [7:0]                 cmd_pstate,
    output logic                       dec_enable,
    output logic                       dec_bypass,
    output logic [1:0]                 dec_n_bin,
    output logic [7:0]                 dec_pstate,
    output logic [7:0]                 dec_data,
    input  logic                       dec_request_byte,
    input  logic [BIN_WIDTH-1:0]       dec_bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIN_WIDTH-1:0]       out_bin,
    output logic [1:0]                 out_n_bin,
    output logic [BINS_CNT_WIDTH-1:0]  bins_decoded,
    output logic [BYTES_CNT_WIDTH-1:0] bytes_consumed,
    output logic                       cmd_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    seq_state_t                 state_r;
    seq_state_t                 next_state_s;
    logic [CNT_W-1:0]           fifo_count_s;
    logic [7:0]                 fifo_head_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       accept_s;
    logic                       bad_cmd_s;
    logic                       good_cmd_s;
    logic                       cmd_ready_s;
    logic                       bs_ready_s;
    logic                       out_valid_r;
    logic [BIN_WIDTH-1:0]       out_bin_r;
    logic [1:0]                 out_n_bin_r;
    logic [BINS_CNT_WIDTH-1:0]  bins_decoded_r;
    logic [BYTES_CNT_WIDTH-1:0] bytes_consumed_r;
    logic                       cmd_err_r;

    // dec_request_byte only reaches pop_s, never the ready terms.
    assign push_s     = bs_valid && bs_ready_s;
    assign accept_s   = cmd_valid && cmd_ready_s;
    assign bad_cmd_s  = accept_s && cmd_bypass && (cmd_n_bin == 2'd0);
    assign good_cmd_s = accept_s && !bad_cmd_s;
    assign pop_s      = good_cmd_s && dec_request_byte;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_byte_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push_s),
        .push_data (bs_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= WAIT_DATA;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: the push edge itself moves us to RUN so ready follows one edge later.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = WAIT_DATA;
        end else begin
            case (state_r)
                WAIT_DATA: begin
                    if (push_s || (fifo_count_s != '0)) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = WAIT_DATA;
                    end
                end
                RUN: begin
                    if (pop_s && !push_s && (fifo_count_s == CNT_W'(1))) begin
                        next_state_s = WAIT_DATA;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                default: next_state_s = WAIT_DATA;
            endcase
        end
    end

    // Handshake and decoder control outputs.
    always_comb begin
        cmd_ready_s = (state_r == RUN) && (fifo_count_s != '0)
                      && (!out_valid_r || out_ready) && !flush;
        bs_ready_s  = (fifo_count_s < DEPTH_CNT) && !flush;
        dec_enable  = good_cmd_s;
        dec_data    = fifo_head_s;
        if (accept_s) begin
            dec_bypass = cmd_bypass;
            dec_n_bin  = cmd_n_bin;
            dec_pstate = cmd_pstate;
        end else begin
            dec_bypass = 1'b0;
            dec_n_bin  = 2'd0;
            dec_pstate = 8'h00;
        end
    end

    // Result register, status counters and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r      <= 1'b0;
            out_bin_r        <= '0;
            out_n_bin_r      <= 2'd0;
            bins_decoded_r   <= '0;
            bytes_consumed_r <= '0;
            cmd_err_r        <= 1'b0;
        end else if (flush) begin
            out_valid_r      <= 1'b0;
            out_bin_r        <= '0;
            out_n_bin_r      <= 2'd0;
            bins_decoded_r   <= '0;
            bytes_consumed_r <= '0;
            cmd_err_r        <= 1'b0;
        end else begin
            if (good_cmd_s) begin
                out_valid_r    <= 1'b1;
                out_bin_r      <= dec_bin;
                out_n_bin_r    <= result_n_bin(cmd_bypass, cmd_n_bin);
                bins_decoded_r <= bins_decoded_r
                                  + BINS_CNT_WIDTH'(result_n_bin(cmd_bypass, cmd_n_bin));
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (pop_s) begin
                bytes_consumed_r <= bytes_consumed_r + BYTES_CNT_WIDTH'(1);
            end
            if (bad_cmd_s) begin
                cmd_err_r <= 1'b1;
            end
        end
    end

    assign cmd_ready      = cmd_ready_s;
    assign bs_ready       = bs_ready_s;
    assign out_valid      = out_valid_r;
    assign out_bin        = out_bin_r;
    assign out_n_bin      = out_n_bin_r;
    assign bins_decoded   = bins_decoded_r;
    assign bytes_consumed = bytes_consumed_r;
    assign cmd_err        = cmd_err_r;

endmodule

// File: tb/tb_bin_decode_sequencer.sv
// Directed bench for bin_decode_sequencer: linear steps, outputs sampled mid-low-phase.
module tb_bin_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        bs_valid = 1'b0;
    logic        bs_ready;
    logic [7:0]  bs_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_bypass = 1'b0;
    logic [1:0]  cmd_n_bin = 2'd0;
    logic [7:0]  cmd_pstate = 8'h00;
    logic        dec_enable;
    logic        dec_bypass;
    logic [1:0]  dec_n_bin;
    logic [7:0]  dec_pstate;
    logic [7:0]  dec_data;
    logic        dec_request_byte = 1'b0;
    logic [2:0]  dec_bin = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_bin;
    logic [1:0]  out_n_bin;
    logic [31:0] bins_decoded;
    logic [23:0] bytes_consumed;
    logic        cmd_err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] drain_bytes [4];

    always #5 clk = ~clk;

    bin_decode_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .bs_valid         (bs_valid),
        .bs_ready         (bs_ready),
        .bs_data          (bs_data),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_bypass       (cmd_bypass),
        .cmd_n_bin        (cmd_n_bin),
        .cmd_pstate       (cmd_pstate),
        .dec_enable       (dec_enable),
        .dec_bypass       (dec_bypass),
        .dec_n_bin        (dec_n_bin),
        .dec_pstate       (dec_pstate),
        .dec_data         (dec_data),
        .dec_request_byte (dec_request_byte),
        .dec_bin          (dec_bin),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_bin          (out_bin),
        .out_n_bin        (out_n_bin),
        .bins_decoded     (bins_decoded),
        .bytes_consumed   (bytes_consumed),
        .cmd_err          (cmd_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drain_bytes[0] = 8'h33;
        drain_bytes[1] = 8'h44;
        drain_bytes[2] = 8'h55;
        drain_bytes[3] = 8'h66;

        // Reset values.
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bins", bins_decoded, 32'd0);
        check("rst_bytes", 32'(bytes_consumed), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_bs_ready", 32'(bs_ready), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_dec_data", 32'(dec_data), 32'd0);
        reset = 1'b0;
        step();

        // Push 0xA5 in cycle 2, ready in cycle 3.
        bs_valid = 1'b1; bs_data = 8'hA5;
        #1 check("push_cmd_ready_before", 32'(cmd_ready), 32'd0);
        step();
        bs_valid = 1'b0;
        #1 check("byte_to_ready", 32'(cmd_ready), 32'd1);
        check("head_a5", 32'(dec_data), 32'hA5);
        check("idle_dec_enable", 32'(dec_enable), 32'd0);

        // Regular command, decoder pulls the byte.
        cmd_valid = 1'b1; cmd_bypass = 1'b0; cmd_n_bin = 2'd0; cmd_pstate = 8'h40;
        dec_request_byte = 1'b1; dec_bin = 3'b001;
        #1 check("reg_dec_enable", 32'(dec_enable), 32'd1);
        check("reg_dec_pstate", 32'(dec_pstate), 32'h40);
        check("reg_dec_bypass", 32'(dec_bypass), 32'd0);
        step();
        cmd_valid = 1'b0; dec_request_byte = 1'b0; cmd_pstate = 8'h00;
        #1 check("reg_out_valid", 32'(out_valid), 32'd1);
        check("reg_out_bin", 32'(out_bin), 32'd1);
        check("reg_out_n_bin", 32'(out_n_bin), 32'd1);
        check("reg_bytes", 32'(bytes_consumed), 32'd1);
        check("reg_bins", bins_decoded, 32'd1);
        check("empty_cmd_ready", 32'(cmd_ready), 32'd0);
        check("empty_dec_data", 32'(dec_data), 32'd0);
        check("idle_dec_pstate", 32'(dec_pstate), 32'd0);

        // Two bytes, then a 3-bin bypass command.
        bs_valid = 1'b1; bs_data = 8'h11;
        step();
        bs_data = 8'h22;
        step();
        bs_valid = 1'b0;
        #1 check("out_valid_drained", 32'(out_valid), 32'd0);
        check("run_cmd_ready", 32'(cmd_ready), 32'd1);
        check("head_11", 32'(dec_data), 32'h11);
        cmd_valid = 1'b1; cmd_bypass = 1'b1; cmd_n_bin = 2'd3;
        dec_request_byte = 1'b1; dec_bin = 3'b101;
        #1 check("byp_dec_n_bin", 32'(dec_n_bin), 32'd3);
        check("byp_dec_bypass", 32'(dec_bypass), 32'd1);
        check("byp_dec_enable", 32'(dec_enable), 32'd1);
        step();
        cmd_valid = 1'b0; dec_request_byte = 1'b0;
        #1 check("byp_out_n_bin", 32'(out_n_bin), 32'd3);
        check("byp_out_bin", 32'(out_bin), 32'b101);
        check("byp_bins", bins_decoded, 32'd4);
        check("byp_bytes", 32'(bytes_consumed), 32'd2);
        check("head_22", 32'(dec_data), 32'h22);

        // Bypass with zero bins: accepted, no result, sticky error.
        cmd_valid = 1'b1; cmd_bypass = 1'b1; cmd_n_bin = 2'd0;
        #1 check("bad_cmd_ready", 32'(cmd_ready), 32'd1);
        check("bad_dec_enable", 32'(dec_enable), 32'd0);
        step();
        cmd_valid = 1'b0; cmd_bypass = 1'b0;
        #1 check("bad_cmd_err", 32'(cmd_err), 32'd1);
        check("bad_no_out_valid", 32'(out_valid), 32'd0);
        check("bad_bins", bins_decoded, 32'd4);
        check("bad_bytes", 32'(bytes_consumed), 32'd2);

        // Output stall holds the result and blocks commands.
        cmd_valid = 1'b1; cmd_pstate = 8'h12; dec_bin = 3'b010; out_ready = 1'b0;
        #1 check("stall_first_accept", 32'(dec_enable), 32'd1);
        step();
        cmd_pstate = 8'h13; dec_bin = 3'b011;
        #1 check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        check("stall_dec_enable", 32'(dec_enable), 32'd0);
        step();
        check("stall_held_valid", 32'(out_valid), 32'd1);
        check("stall_held_bin", 32'(out_bin), 32'b010);
        out_ready = 1'b1;
        #1 check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        check("release_dec_pstate", 32'(dec_pstate), 32'h13);
        step();
        cmd_valid = 1'b0; cmd_pstate = 8'h00;
        #1 check("release_out_bin", 32'(out_bin), 32'b011);
        check("release_bins", bins_decoded, 32'd6);
        check("release_cmd_err_sticky", 32'(cmd_err), 32'd1);

        // Fill: two pushes, push+pop, one push reaches full.
        bs_valid = 1'b1; bs_data = 8'h33;
        step();
        bs_data = 8'h44;
        step();
        bs_data = 8'h55; cmd_valid = 1'b1; dec_request_byte = 1'b1; dec_bin = 3'b000;
        #1 check("pushpop_head", 32'(dec_data), 32'h22);
        step();
        cmd_valid = 1'b0; dec_request_byte = 1'b0; bs_data = 8'h66;
        #1 check("pushpop_head_after", 32'(dec_data), 32'h33);
        check("pushpop_bs_ready", 32'(bs_ready), 32'd1);
        step();
        bs_data = 8'h77;
        #1 check("full_bs_ready", 32'(bs_ready), 32'd0);
        step();
        bs_valid = 1'b0;

        // Drain back to back; 0x77 must not have entered.
        cmd_valid = 1'b1; dec_request_byte = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("drain_head", 32'(dec_data), 32'(drain_bytes[i]));
            check("drain_cmd_ready", 32'(cmd_ready), 32'd1);
            step();
        end
        cmd_valid = 1'b0; dec_request_byte = 1'b0;
        #1 check("drained_cmd_ready", 32'(cmd_ready), 32'd0);
        check("drained_dec_data", 32'(dec_data), 32'd0);
        check("drained_bs_ready", 32'(bs_ready), 32'd1);
        check("drained_bytes", 32'(bytes_consumed), 32'd7);
        check("drained_bins", bins_decoded, 32'd11);

        // Flush during a command stream.
        bs_valid = 1'b1; bs_data = 8'h81;
        step();
        bs_data = 8'h82;
        step();
        bs_valid = 1'b0;
        cmd_valid = 1'b1; cmd_bypass = 1'b1; cmd_n_bin = 2'd2; dec_request_byte = 1'b1; dec_bin = 3'b110;
        #1 check("pre_flush_head", 32'(dec_data), 32'h81);
        step();
        flush = 1'b1; bs_valid = 1'b1; bs_data = 8'h83;
        #1 check("flush_cmd_ready", 32'(cmd_ready), 32'd0);
        check("flush_bs_ready", 32'(bs_ready), 32'd0);
        check("flush_dec_enable", 32'(dec_enable), 32'd0);
        check("pre_flush_out_n_bin", 32'(out_n_bin), 32'd2);
        check("pre_flush_bins", bins_decoded, 32'd13);
        step();
        flush = 1'b0; bs_valid = 1'b0; cmd_valid = 1'b0; cmd_bypass = 1'b0;
        cmd_n_bin = 2'd0; dec_request_byte = 1'b0;
        #1 check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_n_bin", 32'(out_n_bin), 32'd0);
        check("flush_bins", bins_decoded, 32'd0);
        check("flush_bytes", 32'(bytes_consumed), 32'd0);
        check("flush_cmd_err", 32'(cmd_err), 32'd0);
        check("flush_cmd_ready", 32'(cmd_ready), 32'd0);
        check("flush_dec_data", 32'(dec_data), 32'd0);

        // Reset asserted in the middle of an accept.
        bs_valid = 1'b1; bs_data = 8'h91;
        step();
        bs_data = 8'h92;
        step();
        bs_valid = 1'b0; cmd_valid = 1'b1; dec_request_byte = 1'b1; dec_bin = 3'b111;
        #1 check("pre_reset_ready", 32'(cmd_ready), 32'd1);
        step();
        #1 check("mid_accept_enable", 32'(dec_enable), 32'd1);
        check("mid_accept_out_valid", 32'(out_valid), 32'd1);
        check("mid_accept_bins", bins_decoded, 32'd1);
        reset = 1'b1;
        #1 check("reset_dec_enable", 32'(dec_enable), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_dec_data", 32'(dec_data), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_bins", bins_decoded, 32'd0);
        check("reset_bytes", 32'(bytes_consumed), 32'd0);
        check("reset_bs_ready", 32'(bs_ready), 32'd1);
        step();
        check("reset_held_out_valid", 32'(out_valid), 32'd0);
        cmd_valid = 1'b0; dec_request_byte = 1'b0; reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
